// File: rtl/prm_accum_pkg.sv
// Shared constants, FSM states and sizing helper for the PRM edge-mask accumulator.
// Imported by prm_edge_mask_accum and prm_mask_readout.
package prm_accum_pkg;

  localparam int CODE_W      = 15;
  localparam int N_EDGES_DEF = 1024;
  localparam int OUT_W_DEF   = 32;

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    DRAIN,
    READOUT,
    DONE
  } state_t;

  function automatic int n_words(input int n, input int w);
    return n / w;
  endfunction

endpackage

// File: rtl/prm_mask_readout.sv
// Word mux, pointer counter and registered valid/ready word output for the bitmap.
// clear: rewind pointer; en: readout active; bitmap in; out_* stream out.
module prm_mask_readout
  import prm_accum_pkg::*;
#(
  parameter int N_EDGES = N_EDGES_DEF,
  parameter int OUT_W   = OUT_W_DEF,
  parameter int N_WORDS = n_words(N_EDGES, OUT_W),
  parameter int IDX_W   = $clog2(N_WORDS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               en,
  input  logic [N_EDGES-1:0] bitmap,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [OUT_W-1:0]   out_data,
  output logic [IDX_W-1:0]   out_index,
  output logic               out_last
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

  logic [OUT_W-1:0] words [N_WORDS];
  logic [IDX_W-1:0] ptr;
  logic             fire;
  logic             load;

  for (genvar i = 0; i < N_WORDS; i++) begin : g_words
    assign words[i] = bitmap[i*OUT_W +: OUT_W];
  end

  assign fire = out_valid & out_ready;
  // ptr always names the next word to present, so the output
  // register refills on the same edge as a handshake.
  assign load = en & (~out_valid | (fire & ~out_last));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
    end else if (clear) begin
      ptr       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= words[ptr];
      out_index <= ptr;
      out_last  <= (ptr == LAST_IDX);
      ptr       <= ptr + 1'b1;
    end else if (en & fire) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: rtl/prm_edge_mask_accum.sv
// Streams obstacle codes into the PRM checker bank, sticky-ORs the blocked-edge bitmap, drains it as words.
// Ports: start/obs_* in, chk_code/chk_mask bank side, out_* word stream, busy/done status.
module prm_edge_mask_accum
  import prm_accum_pkg::*;
#(
  parameter int N_EDGES = N_EDGES_DEF,
  parameter int OUT_W   = OUT_W_DEF,
  parameter int N_WORDS = n_words(N_EDGES, OUT_W),
  parameter int IDX_W   = $clog2(N_WORDS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               obs_valid,
  output logic               obs_ready,
  input  logic [CODE_W-1:0]  obs_code,
  input  logic               obs_last,
  output logic [CODE_W-1:0]  chk_code,
  input  logic [N_EDGES-1:0] chk_mask,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic [IDX_W-1:0]   out_index,
  output logic               out_last,
  output logic               busy,
  output logic               done
);

  state_t             state_q;
  state_t             state_d;
  logic               chk_vld;
  logic [N_EDGES-1:0] blocked;
  logic               obs_fire;
  logic               rd_finish;
  logic               idle_like;

  assign idle_like = (state_q == IDLE) | (state_q == DONE);
  assign obs_ready = (state_q == ACCUM);
  assign obs_fire  = obs_valid & obs_ready;
  assign rd_finish = out_valid & out_ready & out_last;
  assign busy      = (state_q == ACCUM)
                   | (state_q == DRAIN)
                   | (state_q == READOUT);
  assign done      = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = ACCUM;
      DONE:    if (start) state_d = ACCUM;
      ACCUM:   if (obs_fire && obs_last) state_d = DRAIN;
      DRAIN:   state_d = READOUT;
      READOUT: if (rd_finish) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Code is registered on acceptance; its mask is folded in one
  // cycle later so the bank gets a full cycle to settle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_code <= '0;
      chk_vld  <= 1'b0;
    end else begin
      chk_vld <= obs_fire;
      if (obs_fire) chk_code <= obs_code;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blocked <= '0;
    end else if (idle_like && start) begin
      blocked <= '0;
    end else if (chk_vld) begin
      blocked <= blocked | chk_mask;
    end
  end

  prm_mask_readout #(
    .N_EDGES (N_EDGES),
    .OUT_W   (OUT_W),
    .N_WORDS (N_WORDS),
    .IDX_W   (IDX_W)
  ) u_readout (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (state_q == DRAIN),
    .en        (state_q == READOUT),
    .bitmap    (blocked),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last)
  );

endmodule

// File: tb/tb_prm_edge_mask_accum.sv
// Directed bench for prm_edge_mask_accum with a stub checker bank and word scoreboard.
// Stub maps code c to one-hot edge (c mod 1024) or to all-ones.
module tb_prm_edge_mask_accum;

  localparam int NE = 1024;
  localparam int OW = 32;
  localparam int NW = NE / OW;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  i;
    logic        l;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          obs_valid;
  logic          obs_ready;
  logic [14:0]   obs_code;
  logic          obs_last;
  logic [14:0]   chk_code;
  logic [NE-1:0] chk_mask;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic [4:0]    out_index;
  logic          out_last;
  logic          busy;
  logic          done;

  bit            mode;
  logic [NE-1:0] exp_map;
  logic [14:0]   code_q [$];
  ent_t          sb_q [$];
  int            tests = 0;
  int            fails = 0;

  always #5 clk = ~clk;

  function automatic logic [NE-1:0] stub(input logic [14:0] c, input bit m);
    logic [NE-1:0] r;
    r = m ? '1 : '0;
    if (!m) r[c[9:0]] = 1'b1;
    return r;
  endfunction

  always_comb chk_mask = stub(chk_code, mode);

  prm_edge_mask_accum dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .obs_valid (obs_valid),
    .obs_ready (obs_ready),
    .obs_code  (obs_code),
    .obs_last  (obs_last),
    .chk_code  (chk_code),
    .chk_mask  (chk_mask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_obs_ready"}, 32'(obs_ready), 32'd0);
    check({tag, "_chk_code"},  32'(chk_code),  32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_data"},  out_data,       32'd0);
    check({tag, "_out_index"}, 32'(out_index), 32'd0);
    check({tag, "_out_last"},  32'(out_last),  32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_done"},      32'(done),      32'd0);
  endtask

  task automatic run_frame();
    int cyc;
    int nb;
    ent_t e;
    exp_map = '0;
    nb = code_q.size();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_done", 32'(done), 32'd0);
    for (int k = 0; k < nb; k++) begin
      obs_valid = 1'b1;
      obs_code  = code_q[k];
      obs_last  = (k == nb - 1);
      check("obs_ready_hi", 32'(obs_ready), 32'd1);
      @(posedge clk); #1;
      exp_map = exp_map | stub(code_q[k], mode);
    end
    obs_valid = 1'b0;
    obs_last  = 1'b0;
    check("obs_ready_drop", 32'(obs_ready), 32'd0);
    for (int w = 0; w < NW; w++) begin
      e.d = exp_map[w*OW +: OW];
      e.i = 5'(w);
      e.l = (w == NW - 1);
      sb_q.push_back(e);
    end
    cyc = 0;
    while (!out_valid && cyc < 8) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", 32'(cyc), 32'd2);
  endtask

  task automatic drain(input int pct, input bit poke);
    int   n;
    int   n0;
    int   guard;
    bit   stall;
    logic [31:0] hd;
    logic [4:0]  hi;
    ent_t e;
    n = 0;
    guard = 0;
    n0 = sb_q.size();
    while (sb_q.size() > 0 && guard < 2000) begin
      out_ready = ($urandom_range(99) < pct);
      start = poke && (guard == 3);
      stall = out_valid && !out_ready;
      hd = out_data;
      hi = out_index;
      if (out_valid && out_ready) begin
        e = sb_q.pop_front();
        check("word_data",  out_data,        e.d);
        check("word_index", 32'(out_index),  32'(e.i));
        check("word_last",  32'(out_last),   32'(e.l));
        n++;
      end
      @(posedge clk); #1;
      guard++;
      start = 1'b0;
      if (stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data",  out_data,       hd);
        check("stall_index", 32'(out_index), 32'(hi));
      end
    end
    out_ready = 1'b0;
    check("drain_bound", 32'(guard < 2000), 32'd1);
    check("handshakes",  32'(n),            32'(n0));
    check("end_done",    32'(done),         32'd1);
    check("end_busy",    32'(busy),         32'd0);
    check("end_valid",   32'(out_valid),    32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    obs_valid = 1'b0;
    obs_code  = '0;
    obs_last  = 1'b0;
    out_ready = 1'b0;
    mode      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Abort a frame after three accepted beats.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      obs_valid = 1'b1;
      obs_code  = 15'(k + 1);
      @(posedge clk); #1;
    end
    obs_valid = 1'b0;
    check("pre_abort_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_idle_outputs("abort");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // One-hot codes hitting words 0, 1 and 31.
    mode = 1'b0;
    code_q = {15'd5, 15'd37, 15'd1023};
    run_frame();
    check("frameA_w0",  exp_map[31:0],    32'h0000_0020);
    check("frameA_w1",  exp_map[63:32],   32'h0000_0020);
    check("frameA_w31", exp_map[1023:992], 32'h8000_0000);
    drain(100, 1'b0);

    // Single all-zero code, all-ones mask.
    mode = 1'b1;
    code_q = {15'd0};
    run_frame();
    check("frameB_w7", exp_map[255:224], 32'hFFFF_FFFF);
    drain(100, 1'b0);

    // 100 back-to-back random codes, stalled readout, stray start.
    mode = 1'b0;
    code_q.delete();
    for (int k = 0; k < 100; k++) code_q.push_back(15'($urandom_range(32767)));
    run_frame();
    drain(30, 1'b1);

    // Start straight from DONE; earlier bits must be gone.
    code_q = {15'd5};
    run_frame();
    check("frameD_w1", exp_map[63:32], 32'h0000_0000);
    drain(100, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/prm_edge_mask_accum.md
Name: prm_edge_mask_accum

Overview:
- Downstream consumer of the PRM obstacle-logic checker bank (the `prm_oblgc_chk*` instances).
- Streams quantised obstacle codes, one per accepted beat, into the bank through a registered 15-bit code bus.
- Sticky-ORs each returned per-edge collision bit into an N_EDGES blocked-edge bitmap.
- When the obstacle frame ends, drains the bitmap as OUT_W-bit words over a valid/ready stream to the graph-search / host side.

Parameters:
- N_EDGES, 1024, number of roadmap edges (checker instances); must be a multiple of OUT_W.
- OUT_W, 32, readout word width.
- CODE_W, 15, obstacle code width; bit0 = checker input A, bit14 = checker input O.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse; begins a new frame (clears bitmap).
- obs_valid  in  1  obstacle beat valid.
- obs_ready  out  1  obstacle beat accepted when obs_valid & obs_ready.
- obs_code  in  CODE_W  obstacle code.
- obs_last  in  1  marks final obstacle of the frame.
- chk_code  out  CODE_W  registered code driving the checker bank inputs A..O.
- chk_mask  in  N_EDGES  combinational edge_mask vector returned by the bank for chk_code.
- out_valid  out  1  readout word valid.
- out_ready  in  1  downstream accepts word.
- out_data  out  OUT_W  blocked bits; bit j of word i = edge i*OUT_W+j (1 = collides).
- out_index  out  clog2(N_EDGES/OUT_W)  word index.
- out_last  out  1  final word of the bitmap.
- busy  out  1  high in ACCUM, DRAIN, READOUT.
- done  out  1  high in DONE until the next start.

Behaviour:
- Reset (async, rst_n=0) forces:
  - state=IDLE
  - obs_ready=0, chk_code=0, chk_vld=0
  - blocked=0, word pointer=0
  - out_valid=0, out_data=0, out_index=0, out_last=0
  - busy=0, done=0
- Reset asserted mid-frame aborts the frame; nothing is replayed.
- States: IDLE, ACCUM, DRAIN, READOUT, DONE.
- IDLE/DONE:
  - start -> ACCUM; blocked cleared in the same edge; done drops.
  - start is ignored in ACCUM, DRAIN and READOUT.
- ACCUM:
  - obs_ready=1.
  - On handshake: chk_code<=obs_code and chk_vld<=1, else chk_vld<=0.
  - Whenever chk_vld=1: blocked<=blocked | chk_mask. This is one cycle after acceptance, so the bank has a full cycle of combinational settle.
  - Handshake with obs_last=1 -> DRAIN; obs_ready drops the next cycle.
- DRAIN: one cycle; the last chk_vld OR completes; pointer=0 -> READOUT.
- Obstacle throughput: 1 code/cycle; frame latency from last obstacle to first out_valid = 2 cycles.
- READOUT:
  - out_valid=1, out_data=blocked[ptr*OUT_W +: OUT_W], out_index=ptr, out_last=(ptr==N_EDGES/OUT_W-1).
  - out_data is stable while out_valid & !out_ready.
  - On handshake: ptr++; if out_last -> DONE and out_valid=0.
- Outputs are registered; no combinational path from out_ready to out_valid/out_data.
- A frame requires at least one obstacle beat. A zero-obstacle frame is sent as a single beat with the all-zero code, and the bank result for that code is ORed like any other.
- Duplicate codes are allowed; OR is idempotent.
- Back-to-back frames: start accepted in the DONE cycle; the first beat of the new frame is accepted the following cycle.
- obs_valid outside ACCUM is ignored (obs_ready=0).

Decomposition:
- Package prm_accum_pkg holds:
  - CODE_W and default N_EDGES/OUT_W constants.
  - State enum {IDLE, ACCUM, DRAIN, READOUT, DONE}.
  - A word-count function N_EDGES/OUT_W.
- One natural sub-module, prm_mask_readout: word mux, pointer counter and valid/ready output register. The FSM and bitmap stay in the top.

Test Plan:
- Reset mid-ACCUM after 3 beats -> all outputs 0, state IDLE; the next start runs a clean frame.
- Stub bank maps code c -> one-hot edge (c mod N_EDGES). Codes 5, 37, 1023 (last) -> words 0, 1, 31 = 0x00000020, 0x00000020, 0x80000000; all other words 0; out_last only on index 31.
- Single beat code 15'h0000 with last, stub mask all-ones -> 32 words of 0xFFFFFFFF; first out_valid exactly 2 cycles after acceptance.
- Random out_ready at 30% during readout -> out_data/out_index held while stalled; exactly 32 handshakes; done asserted after the last.
- start pulsed during READOUT -> ignored, readout completes unchanged. start in DONE -> bitmap cleared; the previous frame's bits are absent from the next readout.
- Back-to-back obs_valid=1 for 100 beats of random codes -> bitmap equals the software OR of the stub masks; no beat dropped, obs_ready constant 1 until last.
